commit_trace_buffer: RTL and testbench
======================================

# commit_trace_buffer

Parametrised hardware commit-trace capture buffer for the RISC-V datapath. Records each retired instruction (PC, instruction word, destination register write) into a circular buffer of configurable depth. Streams the records out over a valid/ready port, so register-file evolution is observable without hierarchical probing. Sits beside the datapath's writeback stage and is driven from its commit signals.

## Interface
Parameters:
- XLEN, 32: width of PC and write data.
- DEPTH, 16: buffer entries; power of two, at least 2.
- OVERWRITE, 0: 0 = drop new records when full; 1 = discard oldest when full.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  capture enable.
- commitValid  in  1  an instruction retires this cycle.
- commitPC  in  XLEN  PC of the retiring instruction.
- commitInstr  in  32  instruction word.
- commitRd  in  5  destination register index.
- commitRegWrite  in  1  register file written.
- commitWData  in  XLEN  value written.
- triggerPC  in  XLEN  arming PC; present only with TRACE_TRIGGER_EN.
- outValid  out  1  record available.
- outReady  in  1  consumer accepts record.
- outPC / outInstr / outRd / outRegWrite / outWData  out  XLEN/32/5/1/XLEN  head record fields.
- outSeq  out  16  sequence number of head record.
- count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky; a record was dropped or overwritten.

## Operation
- States: IDLE, ARMED (trigger build only), CAPTURE.
- IDLE -> CAPTURE when enable=1 (non-trigger build). IDLE -> ARMED when enable=1 (trigger build).
- ARMED -> CAPTURE on a commitValid cycle with commitPC == triggerPC. That record is captured.
- Any state -> IDLE when enable=0. Buffer contents are retained and remain readable.
- In CAPTURE, each commitValid cycle is a push. seqCounter increments on every push attempt, including dropped ones, so gaps in outSeq expose drops. seqCounter wraps 0xFFFF -> 0x0000.
- Pop occurs when outValid && outReady.
- Full, OVERWRITE=0:
  - Push with a simultaneous pop is accepted.
  - Push without a pop is dropped, and overflow is set.
- Full, OVERWRITE=1:
  - Push without a pop writes the oldest slot, advances the read pointer, count stays DEPTH, and overflow is set.
  - Push with a simultaneous pop is a normal push+pop, and overflow is not set.
- Empty with a simultaneous push and pop: the pop is ignored because outValid=0. The push lands.
- overflow clears only on reset.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.

## Timing
- Record pushed at edge N appears on out* and raises outValid after edge N, with 1-cycle latency.
- out* are driven from the storage at the read pointer. They are stable while outValid=1 and outReady=0.
- count and overflow update at the same edge as the push or pop.
- Reset values: outValid=0, count=0, overflow=0, outSeq=0, all out* data=0, state=IDLE, pointers=0, seqCounter=0.
- Reset mid-stream discards all entries at that edge. Storage contents need not be cleared, but out* must read 0 while count=0.

## Configuration
- TRACE_TRIGGER_EN defined:
  - triggerPC port and ARMED state exist.
  - Capture begins at the first commit whose PC matches triggerPC.
- Not defined:
  - No triggerPC port and no ARMED state.
  - Capture begins on the first cycle enable=1.

## Structure
- Shared package datapath_pkg holds:
  - trace_record_t: pc, instr, rd, regWrite, wdata, seq.
  - trace_state_t: the state enum.
  - TRACE_SEQ_W = 16.
- One sub-module, trace_ring, holds the storage array, pointers, count and full/empty flags.
- The top level keeps the FSM, seqCounter, overflow and OVERWRITE policy.

## Test plan
- Reset, then enable, then 3 commits with PC 0x0,0x4,0x8 and outReady=0 -> count=3, outPC=0x0, outSeq=0. Pop 3 -> PCs 0x0,0x4,0x8 in order, outValid=0.
- DEPTH=4, OVERWRITE=0: 6 commits, no pops -> count=4, overflow=1, outSeq sequence 0,1,2,3.
- DEPTH=4, OVERWRITE=1: 6 commits, no pops -> count=4, overflow=1, popped outSeq 2,3,4,5.
- Full with a simultaneous push and pop for 10 cycles -> count stays 4, overflow stays 0.
- TRACE_TRIGGER_EN, triggerPC=0x10: commits 0x0..0x1C -> first record outPC=0x10, count=4.
- Reset asserted with count=3 -> next cycle count=0, outValid=0, overflow=0, outSeq=0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath types for the commit-trace capture path.
// Records are sized for the widest supported XLEN; narrower builds zero-pad.
package datapath_pkg;

  localparam int TRACE_SEQ_W    = 16;
  localparam int TRACE_XLEN_MAX = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_XLEN_MAX-1:0] pc;
    logic [31:0]               instr;
    logic [4:0]                rd;
    logic                      regWrite;
    logic [TRACE_XLEN_MAX-1:0] wdata;
    logic [TRACE_SEQ_W-1:0]    seq;
  } trace_record_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side inputs and valid/ready trace output stream.
// master = datapath/consumer side, slave = trace buffer.
interface commit_trace_buffer_if
  import datapath_pkg::*;
#(
  parameter int XLEN = 32
);

  logic                   commitValid;
  logic [XLEN-1:0]        commitPC;
  logic [31:0]            commitInstr;
  logic [4:0]             commitRd;
  logic                   commitRegWrite;
  logic [XLEN-1:0]        commitWData;

  logic                   outValid;
  logic                   outReady;
  logic [XLEN-1:0]        outPC;
  logic [31:0]            outInstr;
  logic [4:0]             outRd;
  logic                   outRegWrite;
  logic [XLEN-1:0]        outWData;
  logic [TRACE_SEQ_W-1:0] outSeq;

  modport master (
    output commitValid, commitPC, commitInstr,
    output commitRd, commitRegWrite, commitWData,
    output outReady,
    input  outValid, outPC, outInstr, outRd,
    input  outRegWrite, outWData, outSeq
  );

  modport slave (
    input  commitValid, commitPC, commitInstr,
    input  commitRd, commitRegWrite, commitWData,
    input  outReady,
    output outValid, outPC, outInstr, outRd,
    output outRegWrite, outWData, outSeq
  );

endinterface

// File: rtl/trace_ring.sv
// Circular record store: storage, wrapping pointers, count, full/empty.
// Head data reads as zero whenever the ring is empty.
module trace_ring
  import datapath_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  trace_record_t wdata_i,
  output trace_record_t rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  trace_record_t mem_q [DEPTH];

  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    count_d = count_q
            + {{AW{1'b0}}, push_i}
            - {{AW{1'b0}}, pop_i};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture buffer: FSM, sequence numbering, full policy.
// Define TRACE_TRIGGER_EN to add triggerPC and the ARMED state.
module commit_trace_buffer
  import datapath_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int OVERWRITE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
`ifdef TRACE_TRIGGER_EN
  input  logic [XLEN-1:0]       triggerPC,
`endif
  commit_trace_buffer_if.slave  bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow
);

  localparam int AW = $clog2(DEPTH);

  trace_state_t           state_q;
  logic [TRACE_SEQ_W-1:0] seq_q;
  logic                   ovf_q;

  trace_record_t rec;
  trace_record_t head;
  logic [AW:0]   ring_count;
  logic          full;
  logic          empty;
  logic          capture;
  logic          push_req;
  logic          pop_ok;
  logic          ring_push;
  logic          ring_pop;

`ifdef TRACE_TRIGGER_EN
  logic hit;
  assign hit     = bus.commitValid && (bus.commitPC == triggerPC);
  assign capture = enable && ((state_q == CAPTURE) || hit);
`else
  assign capture = enable;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else if (!enable) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
`ifdef TRACE_TRIGGER_EN
        IDLE:    state_q <= hit ? CAPTURE : ARMED;
        ARMED:   state_q <= hit ? CAPTURE : ARMED;
`else
        IDLE:    state_q <= CAPTURE;
        ARMED:   state_q <= CAPTURE;
`endif
        CAPTURE: state_q <= CAPTURE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign push_req = capture && bus.commitValid;
  assign pop_ok   = !empty && bus.outReady;

  // Overwrite mode evicts the head to make room instead of dropping.
  assign ring_push = push_req
                  && (!full || pop_ok || (OVERWRITE != 0));
  assign ring_pop  = pop_ok
                  || ((OVERWRITE != 0) && push_req && full);

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_req) seq_q <= seq_q + 1'b1;
      if (push_req && full && !pop_ok) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    rec          = '0;
    rec.pc       = TRACE_XLEN_MAX'(bus.commitPC);
    rec.instr    = bus.commitInstr;
    rec.rd       = bus.commitRd;
    rec.regWrite = bus.commitRegWrite;
    rec.wdata    = TRACE_XLEN_MAX'(bus.commitWData);
    rec.seq      = seq_q;
  end

  trace_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clock   (clock),
    .reset   (reset),
    .push_i  (ring_push),
    .pop_i   (ring_pop),
    .wdata_i (rec),
    .rdata_o (head),
    .count_o (ring_count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.outValid    = !empty;
  assign bus.outPC       = head.pc[XLEN-1:0];
  assign bus.outInstr    = head.instr;
  assign bus.outRd       = head.rd;
  assign bus.outRegWrite = head.regWrite;
  assign bus.outWData    = head.wdata[XLEN-1:0];
  assign bus.outSeq      = head.seq;
  assign count           = ring_count;
  assign overflow        = ovf_q;

  if (XLEN < TRACE_XLEN_MAX) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^{head.pc[TRACE_XLEN_MAX-1:XLEN],
                         head.wdata[TRACE_XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench: drop-mode and overwrite-mode buffers, DEPTH=4,
// fed identical commits, checked against a queue-based reference model.
module tb_commit_trace_buffer;
  import datapath_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int HW    = 32 + 32 + 5 + 1 + 32 + 16;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] wd;
    logic [15:0] seq;
  } rec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, enable, cv, rw, rdy0, rdy1;
  logic [31:0] pc, instr, wd, trig;
  logic [4:0]  rd;
  logic [CW-1:0] cnt0, cnt1;
  logic        ovf0, ovf1;

  commit_trace_buffer_if #(.XLEN(XLEN)) b0 ();
  commit_trace_buffer_if #(.XLEN(XLEN)) b1 ();

  assign b0.commitValid = cv;     assign b1.commitValid = cv;
  assign b0.commitPC = pc;        assign b1.commitPC = pc;
  assign b0.commitInstr = instr;  assign b1.commitInstr = instr;
  assign b0.commitRd = rd;        assign b1.commitRd = rd;
  assign b0.commitRegWrite = rw;  assign b1.commitRegWrite = rw;
  assign b0.commitWData = wd;     assign b1.commitWData = wd;
  assign b0.outReady = rdy0;      assign b1.outReady = rdy1;

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .OVERWRITE(0)) u0 (
    .clock(clock), .reset(reset), .enable(enable),
`ifdef TRACE_TRIGGER_EN
    .triggerPC(trig),
`endif
    .bus(b0.slave), .count(cnt0), .overflow(ovf0)
  );

  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .OVERWRITE(1)) u1 (
    .clock(clock), .reset(reset), .enable(enable),
`ifdef TRACE_TRIGGER_EN
    .triggerPC(trig),
`endif
    .bus(b1.slave), .count(cnt1), .overflow(ovf1)
  );

  int tests = 0;
  int fails = 0;

  rec_t        q0[$];
  rec_t        q1[$];
  logic [15:0] mseq;
  bit          mstart, movf0, movf1;

  // Reference: one step of the capture rules applied to the current inputs.
  task automatic model_step();
    rec_t r;
    bit cap, push, p0, p1;
    if (reset) begin
      q0.delete(); q1.delete();
      mseq = '0; mstart = 0; movf0 = 0; movf1 = 0;
      return;
    end
`ifdef TRACE_TRIGGER_EN
    cap = enable && (mstart || (cv && pc == trig));
    mstart = cap;
`else
    cap = enable;
`endif
    push = cap && cv;
    p0 = (q0.size() != 0) && rdy0;
    p1 = (q1.size() != 0) && rdy1;
    r = '{pc, instr, rd, rw, wd, mseq};
    if (push) mseq = mseq + 16'd1;
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (push) begin
      if (q0.size() < DEPTH) q0.push_back(r);
      else movf0 = 1;
      if (q1.size() == DEPTH) begin
        void'(q1.pop_front());
        movf1 = 1;
      end
      q1.push_back(r);
    end
  endtask

  function automatic logic [HW-1:0] mhead(input bit which);
    rec_t r;
    if (which ? q1.size() == 0 : q0.size() == 0) return '0;
    r = which ? q1[0] : q0[0];
    return {r.pc, r.instr, r.rd, r.rw, r.wd, r.seq};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic commit(input logic [31:0] p);
    cv = 1'b1; pc = p;
    instr = $urandom; wd = $urandom;
    rd = 5'($urandom_range(0, 31));
    rw = 1'($urandom_range(0, 1));
    tick();
    cv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({b0.outValid, cnt0, ovf0} !== '0) begin
      fails++;
      $display("FAIL reset_flags0 got %0h want 0", {b0.outValid, cnt0, ovf0});
    end
    tests++;
    if ({b1.outValid, cnt1, ovf1} !== '0) begin
      fails++;
      $display("FAIL reset_flags1 got %0h want 0", {b1.outValid, cnt1, ovf1});
    end
    tests++;
    if ({b0.outSeq, b0.outPC, b0.outWData} !== '0) begin
      fails++;
      $display("FAIL reset_data got seq %0h pc %0h want 0", b0.outSeq, b0.outPC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    do_reset();
    enable = 1'b1;
    commit(32'h0); commit(32'h4); commit(32'h8);
    tests++;
    if (cnt0 !== CW'(3)) begin
      fails++; $display("FAIL basic_count got %0d want 3", cnt0);
    end
    tests++;
    if (b0.outPC !== 32'h0 || b0.outSeq !== 16'h0) begin
      fails++;
      $display("FAIL basic_head got pc %0h seq %0h want 0 0", b0.outPC, b0.outSeq);
    end
    rdy0 = 1'b1; rdy1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(4 * i);
      tests++;
      if (b0.outValid !== 1'b1 || b0.outPC !== exp_pc) begin
        fails++;
        $display("FAIL basic_pop%0d got v %0b pc %0h want 1 %0h",
                 i, b0.outValid, b0.outPC, exp_pc);
      end
      tick();
    end
    rdy0 = 1'b0; rdy1 = 1'b0;
    tests++;
    if (b0.outValid !== 1'b0 || cnt0 !== '0) begin
      fails++;
      $display("FAIL basic_empty got v %0b cnt %0d want 0 0", b0.outValid, cnt0);
    end
  endtask

  task automatic test_full_policy();
    logic [15:0] e0, e1;
    do_reset();
    for (int i = 0; i < 6; i++) commit(32'(4 * i));
    tests++;
    if (cnt0 !== CW'(4) || ovf0 !== 1'b1) begin
      fails++; $display("FAIL drop_full got cnt %0d ovf %0b want 4 1", cnt0, ovf0);
    end
    tests++;
    if (cnt1 !== CW'(4) || ovf1 !== 1'b1) begin
      fails++; $display("FAIL ovw_full got cnt %0d ovf %0b want 4 1", cnt1, ovf1);
    end
    rdy0 = 1'b1; rdy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e0 = 16'(i);
      e1 = 16'(i + 2);
      tests++;
      if (b0.outSeq !== e0 || b1.outSeq !== e1) begin
        fails++;
        $display("FAIL full_seq%0d got %0d/%0d want %0d/%0d",
                 i, b0.outSeq, b1.outSeq, e0, e1);
      end
      tick();
    end
    rdy0 = 1'b0; rdy1 = 1'b0;
    tests++;
    if (b0.outValid !== 1'b0 || b1.outValid !== 1'b0) begin
      fails++; $display("FAIL full_drain got %0b/%0b want 0/0", b0.outValid, b1.outValid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) commit(32'h100 + 32'(4 * i));
    rdy0 = 1'b1; rdy1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cv = 1'b1; pc = 32'h200 + 32'(4 * k);
      tick();
      tests++;
      if (cnt0 !== CW'(4) || cnt1 !== CW'(4) || ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
        fails++;
        $display("FAIL b2b_%0d got cnt %0d/%0d ovf %0b/%0b want 4/4 0/0",
                 k, cnt0, cnt1, ovf0, ovf1);
      end
      tests++;
      if (b0.outSeq !== 16'(k + 1) || b1.outSeq !== 16'(k + 1)) begin
        fails++;
        $display("FAIL b2b_seq%0d got %0d/%0d want %0d", k, b0.outSeq, b1.outSeq, k + 1);
      end
    end
    cv = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
  endtask

`ifdef TRACE_TRIGGER_EN
  task automatic test_trigger();
    do_reset();
    trig = 32'h10;
    for (int i = 0; i < 8; i++) commit(32'(4 * i));
    tests++;
    if (b0.outPC !== 32'h10 || cnt0 !== CW'(4)) begin
      fails++; $display("FAIL trigger got pc %0h cnt %0d want 10 4", b0.outPC, cnt0);
    end
    trig = 32'h0;
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) commit(32'h40 + 32'(4 * i));
    rdy0 = 1'b1; tick(); rdy0 = 1'b0;
    tests++;
    if (cnt0 !== CW'(3) || ovf0 !== 1'b1) begin
      fails++; $display("FAIL mid_pre got cnt %0d ovf %0b want 3 1", cnt0, ovf0);
    end
    do_reset();
    tests++;
    if ({cnt0, b0.outValid, ovf0, b0.outSeq, b0.outPC} !== '0) begin
      fails++;
      $display("FAIL mid_reset got cnt %0d v %0b ovf %0b seq %0h want 0",
               cnt0, b0.outValid, ovf0, b0.outSeq);
    end
  endtask

  task automatic test_random();
    logic [HW-1:0] g0, g1;
    do_reset();
`ifdef TRACE_TRIGGER_EN
    trig = 32'h20;
`endif
    for (int n = 0; n < 600; n++) begin
      reset  = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 7) != 0);
      cv     = 1'($urandom_range(0, 1));
      pc     = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      instr  = $urandom; wd = $urandom;
      rd     = 5'($urandom_range(0, 31));
      rw     = 1'($urandom_range(0, 1));
      rdy0   = ($urandom_range(0, 2) == 0);
      rdy1   = ($urandom_range(0, 2) == 0);
      tick();
      g0 = {b0.outPC, b0.outInstr, b0.outRd, b0.outRegWrite, b0.outWData, b0.outSeq};
      g1 = {b1.outPC, b1.outInstr, b1.outRd, b1.outRegWrite, b1.outWData, b1.outSeq};
      tests++;
      if (cnt0 !== CW'(q0.size()) || ovf0 !== movf0 || b0.outValid !== (q0.size() != 0)
          || g0 !== mhead(0)) begin
        fails++;
        $display("FAIL rand0_%0d got cnt %0d ovf %0b head %0h want %0d %0b %0h",
                 n, cnt0, ovf0, g0, q0.size(), movf0, mhead(0));
      end
      tests++;
      if (cnt1 !== CW'(q1.size()) || ovf1 !== movf1 || b1.outValid !== (q1.size() != 0)
          || g1 !== mhead(1)) begin
        fails++;
        $display("FAIL rand1_%0d got cnt %0d ovf %0b head %0h want %0d %0b %0h",
                 n, cnt1, ovf1, g1, q1.size(), movf1, mhead(1));
      end
    end
    reset = 1'b0; cv = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cv = 1'b0; rw = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0;
    pc = '0; instr = '0; wd = '0; rd = '0; trig = '0;
    mseq = '0; mstart = 0; movf0 = 0; movf1 = 0;
    test_reset();
    test_basic();
    test_full_policy();
    test_back_to_back();
`ifdef TRACE_TRIGGER_EN
    test_trigger();
`endif
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
